axi4_lite_cmd_arbiter: RTL and testbench

- Shares the single AXI4-Lite master command interface (START_READ/START_WRITE, address, W_data) between two requesters.
- Round-robin grant; one transaction outstanding at a time.
- Sequences each transaction: accept, issue a 1-cycle start pulse, wait for R or B completion, return the response to the owning requester.
- Sits between client logic and axi4_lite_master in the AXI-Lite subsystem.

---
 rtl/axi4_lite_cmd_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_axi4_lite_cmd_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of an AXI4-Lite master.
// Define AXIL_ARB_TIMEOUT_EN to force an SLVERR completion after TIMEOUT_CYCLES wait cycles.
module axi4_lite_cmd_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS        = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_rnw,
   input  logic [2*ADDRESS-1:0]    req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   input  logic [1:0]              rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    start_read,
   output logic                    start_write,
   output logic [ADDRESS-1:0]      address,
   output logic [DATA_WIDTH-1:0]   W_data,
   input  logic                    m_rvalid,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_bvalid,
   input  logic [1:0]              m_bresp,
   output logic                    busy,
   output logic                    grant_id
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RD,
      S_WAIT_WR,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic                  grant_q, grant_d;
   logic                  rnw_q, rnw_d;
   logic [ADDRESS-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  win;
   logic                  timeout;

   // On a tie the requester that was not served last wins.
   always_comb begin
      win = 1'b0;
      case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_q;
         default: win = 1'b0;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if (state_q == S_IDLE) begin
         req_ready = req_valid & (win ? 2'b10 : 2'b01);
      end
   end

`ifdef AXIL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (state_q == S_WAIT_RD || state_q == S_WAIT_WR) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   // Wait states never expire in this build.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      rnw_d       = rnw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      start_read  = 1'b0;
      start_write = 1'b0;
      rsp_valid   = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (|req_ready) begin
               grant_d = win;
               rnw_d   = req_rnw[win];
               addr_d  = win ? req_addr[ADDRESS +: ADDRESS]
                             : req_addr[0 +: ADDRESS];
               wdata_d = win ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                             : req_wdata[0 +: DATA_WIDTH];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            start_read  = rnw_q;
            start_write = ~rnw_q;
            state_d     = rnw_q ? S_WAIT_RD : S_WAIT_WR;
         end
         S_WAIT_RD: begin
            if (m_rvalid) begin
               rdata_d = m_rdata;
               resp_d  = m_rresp;
               state_d = S_RESP;
            end else if (timeout) begin
               rdata_d = '0;
               resp_d  = 2'b10;
               state_d = S_RESP;
            end
         end
         S_WAIT_WR: begin
            if (m_bvalid) begin
               rdata_d = '0;
               resp_d  = m_bresp;
               state_d = S_RESP;
            end else if (timeout) begin
               rdata_d = '0;
               resp_d  = 2'b10;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = grant_q ? 2'b10 : 2'b01;
            if (rsp_ready[grant_q]) begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         grant_q <= 1'b0;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         rnw_q   <= rnw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end

   assign address   = addr_q;
   assign W_data    = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;
   assign busy      = (state_q != S_IDLE);
   assign grant_id  = grant_q;

endmodule

// File: tb/tb_axi4_lite_cmd_arbiter.sv
// Scoreboard bench for axi4_lite_cmd_arbiter: random requesters and slave,
// queue-based reference of grant order, issued commands and responses.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_axi4_lite_cmd_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic [1:0]      req_valid, req_ready, req_rnw;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]      rsp_valid, rsp_ready, rsp_resp;
   logic [DW-1:0]   rsp_rdata, W_data, m_rdata;
   logic [AW-1:0]   address;
   logic            start_read, start_write;
   logic            m_rvalid, m_bvalid;
   logic [1:0]      m_rresp, m_bresp;
   logic            busy, grant_id;

   logic          rv[2];
   logic          rrnw[2];
   logic [AW-1:0] raddr[2];
   logic [DW-1:0] rwd[2];

   assign req_valid = {rv[1], rv[0]};
   assign req_rnw   = {rrnw[1], rrnw[0]};
   assign req_addr  = {raddr[1], raddr[0]};
   assign req_wdata = {rwd[1], rwd[0]};

   axi4_lite_cmd_arbiter #(
      .DATA_WIDTH(DW), .ADDRESS(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .start_read(start_read), .start_write(start_write),
      .address(address), .W_data(W_data),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_bvalid(m_bvalid), .m_bresp(m_bresp),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic          id;
      logic          rnw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
      int            ccyc;
   } rsp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   cmd_t acc_q[$];
   cmd_t fly_q[$];
   rsp_t dat_q[$];
   int   glog[$];
   bit   outstanding = 1'b0;
   logic last_m = 1'b1;
   bit   rsp_first = 1'b0;
   int   acc_cyc = 0;
   bit   slave_en = 1'b1;
   int   fixed_lat = -1;
   bit   force_en = 1'b0;
   logic [DW-1:0] force_data = '0;
   bit   rnd_ready = 1'b0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   function automatic logic [1:0] exp_ready(input logic [1:0] v,
                                            input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // Monitor: compares every DUT output event against the queues.
   cmd_t mc;
   rsp_t mr;
   always @(negedge ACLK) begin
      if (ARESET) begin
         acc_q.delete();
         fly_q.delete();
         dat_q.delete();
         outstanding = 1'b0;
         last_m = 1'b1;
      end else begin
         if (outstanding) `CHK("no_accept_busy", req_ready, 2'b00);
         else if (req_valid != 2'b00)
            `CHK("grant", req_ready, exp_ready(req_valid, last_m));
         if (|(req_ready & req_valid)) begin
            mc.id    = req_ready[1];
            mc.rnw   = rrnw[mc.id];
            mc.addr  = raddr[mc.id];
            mc.wdata = rwd[mc.id];
            acc_q.push_back(mc);
            outstanding = 1'b1;
            acc_cyc = cyc;
         end
         if (start_read || start_write) begin
            if (acc_q.size() == 0) fail("spurious_start");
            else begin
               mc = acc_q.pop_front();
               `CHK("start_cycle", cyc, acc_cyc + 1);
               `CHK("start_type", {start_read, start_write}, {mc.rnw, ~mc.rnw});
               `CHK("issue_addr", address, mc.addr);
               `CHK("issue_wdata", W_data, mc.wdata);
               fly_q.push_back(mc);
               rsp_first = 1'b1;
            end
         end else if (fly_q.size() != 0) begin
            `CHK("addr_hold", address, fly_q[0].addr);
            `CHK("wdata_hold", W_data, fly_q[0].wdata);
         end
         if (rsp_valid != 2'b00) begin
            if (fly_q.size() == 0 || dat_q.size() == 0) fail("spurious_rsp");
            else begin
               mc = fly_q[0];
               mr = dat_q[0];
               `CHK("rsp_valid", rsp_valid, mc.id ? 2'b10 : 2'b01);
               `CHK("rsp_rdata", rsp_rdata, mr.rdata);
               `CHK("rsp_resp", rsp_resp, mr.resp);
               if (rsp_first && mr.ccyc >= 0)
                  `CHK("rsp_latency", cyc, mr.ccyc + 1);
               rsp_first = 1'b0;
               if (rsp_ready[mc.id]) begin
                  void'(fly_q.pop_front());
                  void'(dat_q.pop_front());
                  last_m = mc.id;
                  glog.push_back(int'(mc.id));
                  outstanding = 1'b0;
               end
            end
         end
      end
   end

   // Slave model: answers each start pulse after 0..3 wait cycles,
   // waving the other completion type meanwhile.
   initial begin
      logic rd;
      int   lat;
      rsp_t e;
      m_rvalid = 1'b0; m_bvalid = 1'b0;
      m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
      forever begin
         @(negedge ACLK);
         if (slave_en && !ARESET && (start_read || start_write)) begin
            rd  = start_read;
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            @(posedge ACLK); #1;
            repeat (lat) begin
               m_rvalid = rd ? 1'b0 : 1'($urandom_range(0, 1));
               m_bvalid = rd ? 1'($urandom_range(0, 1)) : 1'b0;
               m_rdata  = $urandom;
               m_rresp  = 2'($urandom);
               m_bresp  = 2'($urandom);
               @(posedge ACLK); #1;
            end
            m_rdata  = force_en ? force_data : $urandom;
            m_rresp  = 2'($urandom);
            m_bresp  = 2'($urandom);
            m_rvalid = rd;
            m_bvalid = ~rd;
            e.rdata  = rd ? m_rdata : '0;
            e.resp   = rd ? m_rresp : m_bresp;
            e.ccyc   = cyc;
            dat_q.push_back(e);
            @(posedge ACLK); #1;
            m_rvalid = 1'b0;
            m_bvalid = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge ACLK); #1;
         if (rnd_ready) rsp_ready = 2'($urandom);
      end
   end

   task automatic drive_req(input int i, input logic rnw,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      rrnw[i] = rnw; raddr[i] = a; rwd[i] = d; rv[i] = 1'b1;
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!req_ready[i] && n < 400);
      if (!req_ready[i]) fail("accept_timeout");
      @(posedge ACLK); #1;
      rv[i] = 1'b0;
   endtask

   task automatic rand_req(input int i, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         int g;
         g = $urandom_range(0, 4);
         if (g > 0) begin
            repeat (g) @(posedge ACLK);
            #1;
         end
         drive_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || rv[0] || rv[1] || outstanding) && n < 3000) begin
         @(negedge ACLK);
         n++;
      end
      if (n >= 3000) fail("idle_timeout");
      @(posedge ACLK); #1;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
   endtask

   initial begin
      int   n, g0;
      rsp_t e;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; rrnw[i] = 1'b0; raddr[i] = '0; rwd[i] = '0;
      end
      rsp_ready = 2'b11;
      ARESET = 1'b1;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      `CHK("rst_req_ready", req_ready, 2'b00);
      `CHK("rst_rsp_valid", rsp_valid, 2'b00);
      `CHK("rst_rsp_rdata", rsp_rdata, 0);
      `CHK("rst_rsp_resp", rsp_resp, 2'b00);
      `CHK("rst_start", {start_read, start_write}, 2'b00);
      `CHK("rst_address", address, 0);
      `CHK("rst_wdata", W_data, 0);
      `CHK("rst_busy", busy, 1'b0);
      `CHK("rst_grant_id", grant_id, 1'b0);
      @(posedge ACLK); #1;
      ARESET = 1'b0;

      fork
         drive_req(0, 1'b1, 32'h100, 32'h0);
         drive_req(1, 1'b0, 32'h104, 32'h55);
         begin
            @(negedge ACLK);
            `CHK("tie_first", req_ready, 2'b01);
         end
      join
      wait_idle();

      fixed_lat = 2;
      drive_req(1, 1'b0, 32'h10, 32'hDEADBEEF);
      wait_idle();

      fixed_lat = 0;
      force_en = 1'b1;
      force_data = 32'hDEADBEEF;
      rsp_ready = 2'b00;
      drive_req(0, 1'b1, 32'h10, 32'h0);
      n = 0;
      while (rsp_valid == 2'b00 && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      if (rsp_valid == 2'b00) fail("read_rsp_timeout");
      @(posedge ACLK); #1;
      fork
         drive_req(1, 1'b1, 32'h20, 32'h0);
      join_none
      repeat (5) begin
         @(negedge ACLK);
         `CHK("hold_valid", rsp_valid, 2'b01);
         `CHK("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      end
      @(posedge ACLK); #1;
      rsp_ready = 2'b11;
      wait_idle();
      fixed_lat = -1;
      force_en = 1'b0;

      do_reset();
      g0 = glog.size();
      fork
         for (int k = 0; k < 3; k++) drive_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
         for (int k = 0; k < 3; k++) drive_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      join
      wait_idle();
      if (glog.size() < g0 + 6) fail("fair_count");
      else for (int k = 0; k < 6; k++) `CHK("fair_order", glog[g0 + k], k % 2);

      rnd_ready = 1'b1;
      fork
         rand_req(0, 25);
         rand_req(1, 25);
      join
      rnd_ready = 1'b0;
      @(posedge ACLK); #2;
      rsp_ready = 2'b11;
      wait_idle();

      slave_en = 1'b0;
      drive_req(0, 1'b1, 32'h30, 32'h0);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      do_reset();
      @(negedge ACLK);
      `CHK("rst_mid_busy", busy, 1'b0);
      `CHK("rst_mid_rsp", rsp_valid, 2'b00);
      @(posedge ACLK); #1;
      m_rvalid = 1'b1;
      m_rdata = 32'hCAFE0001;
      @(posedge ACLK); #1;
      m_rvalid = 1'b0;
      repeat (3) begin
         @(negedge ACLK);
         `CHK("late_r_busy", busy, 1'b0);
         `CHK("late_r_rsp", rsp_valid, 2'b00);
      end
      @(posedge ACLK); #1;

`ifdef AXIL_ARB_TIMEOUT_EN
      e.rdata = '0;
      e.resp = 2'b10;
      e.ccyc = -1;
      dat_q.push_back(e);
      drive_req(0, 1'b1, 32'h40, 32'h0);
      n = 0;
      while (!rsp_valid[0] && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      `CHK("timeout_cycles", n, 10);
      wait_idle();
`else
      drive_req(0, 1'b1, 32'h40, 32'h0);
      repeat (40) @(negedge ACLK);
      `CHK("stall_busy", busy, 1'b1);
      `CHK("stall_rsp", rsp_valid, 2'b00);
      @(posedge ACLK); #1;
      do_reset();
`endif

      slave_en = 1'b1;
      drive_req(1, 1'b0, 32'h44, 32'h1234);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=done");
      $fatal(1);
   end

endmodule
